// File: rtl/redmule_tile_if.sv
// Tile descriptor handshake between the RedMulE tile scheduler and the streamer/buffer control.
// The master presents one descriptor per valid/ready handshake.
interface redmule_tile_if #(
  parameter int unsigned ITER_W = 16,
  parameter int unsigned LFT_W  = 8
);
  logic              tile_valid;
  logic              tile_ready;
  logic [ITER_W-1:0] tile_m;
  logic [ITER_W-1:0] tile_k;
  logic [ITER_W-1:0] tile_n;
  logic [LFT_W-1:0]  tile_m_size;
  logic [LFT_W-1:0]  tile_k_size;
  logic [LFT_W-1:0]  tile_n_size;
  logic              tile_first;
  logic              tile_last;

  modport master (
    output tile_valid, tile_m, tile_k, tile_n,
           tile_m_size, tile_k_size, tile_n_size, tile_first, tile_last,
    input  tile_ready
  );

  modport slave (
    input  tile_valid, tile_m, tile_k, tile_n,
           tile_m_size, tile_k_size, tile_n_size, tile_first, tile_last,
    output tile_ready
  );
endinterface

// File: rtl/redmule_tile_sched.sv
// RedMulE tile-iteration scheduler: walks M (outer), K (middle), N (inner) tiles of Z = X*W (+Y)
// and issues one registered descriptor per handshake with leftover-aware sizes and store count.
module redmule_tile_sched #(
  parameter int unsigned ARRAY_HEIGHT = 4,
  parameter int unsigned PIPE_REGS    = 3,
  parameter int unsigned ARRAY_WIDTH  = 12,
  parameter int unsigned ITER_W       = 16,
  parameter int unsigned LFT_W        = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [ITER_W-1:0]   m_iters_i,
  input  logic [ITER_W-1:0]   n_iters_i,
  input  logic [ITER_W-1:0]   k_iters_i,
  input  logic [LFT_W-1:0]    m_lft_i,
  input  logic [LFT_W-1:0]    n_lft_i,
  input  logic [LFT_W-1:0]    k_lft_i,
  redmule_tile_if.master      tile,
  output logic [2*ITER_W-1:0] stores_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned TILE_K = (PIPE_REGS + 1) * ARRAY_HEIGHT;
  localparam int unsigned ST_W   = 2 * ITER_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] m_q, k_q, n_q, m_d, k_d, n_d;
  logic [ITER_W-1:0] m_last_q, k_last_q, n_last_q, m_last_d, k_last_d, n_last_d;
  logic [LFT_W-1:0]  m_lft_q, k_lft_q, n_lft_q, m_lft_d, k_lft_d, n_lft_d;
  logic [LFT_W-1:0]  m_size_q, k_size_q, n_size_q, m_size_d, k_size_d, n_size_d;
  logic              first_q, last_q, first_d, last_d;
  logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [ST_W-1:0]   stores_q, stores_d;
  logic              hs, zero_cnt;

  assign hs       = valid_q & tile.tile_ready;
  assign zero_cnt = (m_iters_i == '0) || (k_iters_i == '0) || (n_iters_i == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      m_last_q <= '0;
      k_last_q <= '0;
      n_last_q <= '0;
      m_lft_q  <= '0;
      k_lft_q  <= '0;
      n_lft_q  <= '0;
      m_size_q <= '0;
      k_size_q <= '0;
      n_size_q <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stores_q <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      k_q      <= k_d;
      n_q      <= n_d;
      m_last_q <= m_last_d;
      k_last_q <= k_last_d;
      n_last_q <= n_last_d;
      m_lft_q  <= m_lft_d;
      k_lft_q  <= k_lft_d;
      n_lft_q  <= n_lft_d;
      m_size_q <= m_size_d;
      k_size_q <= k_size_d;
      n_size_q <= n_size_d;
      first_q  <= first_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      stores_q <= stores_d;
    end
  end

  // Next state, counter walk and the descriptor that will be presented next cycle.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    k_d      = k_q;
    n_d      = n_q;
    m_last_d = m_last_q;
    k_last_d = k_last_q;
    n_last_d = n_last_q;
    m_lft_d  = m_lft_q;
    k_lft_d  = k_lft_q;
    n_lft_d  = n_lft_q;
    stores_d = stores_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          m_last_d = m_iters_i - ITER_W'(1);
          k_last_d = k_iters_i - ITER_W'(1);
          n_last_d = n_iters_i - ITER_W'(1);
          m_lft_d  = m_lft_i;
          k_lft_d  = k_lft_i;
          n_lft_d  = n_lft_i;
          m_d      = '0;
          k_d      = '0;
          n_d      = '0;
          stores_d = '0;
          state_d  = zero_cnt ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          if (last_q) stores_d = stores_q + ST_W'(1);
          if (n_q != n_last_q) begin
            n_d = n_q + ITER_W'(1);
          end else begin
            n_d = '0;
            if (k_q != k_last_q) begin
              k_d = k_q + ITER_W'(1);
            end else begin
              k_d = '0;
              if (m_q != m_last_q) begin
                m_d = m_q + ITER_W'(1);
              end else begin
                m_d     = '0;
                state_d = DONE;
              end
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Soft clear wins over start and over a handshake in the same cycle.
    if (clear_i) begin
      state_d  = IDLE;
      m_d      = '0;
      k_d      = '0;
      n_d      = '0;
      stores_d = '0;
      done_d   = 1'b0;
    end

    valid_d  = (state_d == ISSUE);
    busy_d   = (state_d != IDLE);
    first_d  = valid_d && (n_d == '0);
    last_d   = valid_d && (n_d == n_last_d);
    m_size_d = !valid_d ? '0 :
               ((m_d == m_last_d) && (m_lft_d != '0)) ? m_lft_d : LFT_W'(ARRAY_WIDTH);
    k_size_d = !valid_d ? '0 :
               ((k_d == k_last_d) && (k_lft_d != '0)) ? k_lft_d : LFT_W'(TILE_K);
    n_size_d = !valid_d ? '0 :
               ((n_d == n_last_d) && (n_lft_d != '0)) ? n_lft_d : LFT_W'(ARRAY_HEIGHT);
  end

  assign tile.tile_valid  = valid_q;
  assign tile.tile_m      = m_q;
  assign tile.tile_k      = k_q;
  assign tile.tile_n      = n_q;
  assign tile.tile_m_size = m_size_q;
  assign tile.tile_k_size = k_size_q;
  assign tile.tile_n_size = n_size_q;
  assign tile.tile_first  = first_q;
  assign tile.tile_last   = last_q;
  assign stores_o         = stores_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_redmule_tile_sched.sv
// Scoreboard bench for redmule_tile_sched: a loop-nest reference model queues expected
// descriptors; a negedge monitor pops and compares on every accepted tile.
module tb_redmule_tile_sched;

  localparam int unsigned ITER_W = 16;
  localparam int unsigned LFT_W  = 8;
  localparam int unsigned AH     = 4;
  localparam int unsigned AW     = 12;
  localparam int unsigned PR     = 3;
  localparam int unsigned TK     = (PR + 1) * AH;

  typedef struct {
    int     m, k, n, ms, ks, ns;
    bit     first, last;
    longint st;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clear, start;
  logic [ITER_W-1:0]   m_iters, n_iters, k_iters;
  logic [LFT_W-1:0]    m_lft, n_lft, k_lft;
  logic [2*ITER_W-1:0] stores;
  logic                busy, done;

  redmule_tile_if #(.ITER_W(ITER_W), .LFT_W(LFT_W)) tif ();

  redmule_tile_sched #(
    .ARRAY_HEIGHT(AH), .PIPE_REGS(PR), .ARRAY_WIDTH(AW), .ITER_W(ITER_W), .LFT_W(LFT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .m_iters_i(m_iters), .n_iters_i(n_iters), .k_iters_i(k_iters),
    .m_lft_i(m_lft), .n_lft_i(n_lft), .k_lft_i(k_lft),
    .tile(tif.master),
    .stores_o(stores), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           acc_cnt = 0;
  int           done_cnt = 0;
  int           ready_pct = 100;
  exp_t         q[$];
  bit           prev_stall = 1'b0;
  logic [127:0] prev_desc = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pack_exp(input exp_t e);
    return 128'({16'(e.m), 16'(e.k), 16'(e.n), 8'(e.ms), 8'(e.ks), 8'(e.ns), e.first, e.last});
  endfunction

  function automatic logic [127:0] pack_act();
    return 128'({tif.tile_m, tif.tile_k, tif.tile_n, tif.tile_m_size, tif.tile_k_size,
                 tif.tile_n_size, tif.tile_first, tif.tile_last});
  endfunction

  // Reference model: plain loop nest over the tile space, M outer, K middle, N inner.
  task automatic build_exp(input int mi, input int ki, input int ni,
                           input int ml, input int kl, input int nl);
    exp_t e;
    for (int m = 0; m < mi; m++)
      for (int k = 0; k < ki; k++)
        for (int n = 0; n < ni; n++) begin
          e.m = m; e.k = k; e.n = n;
          e.ms = (m == mi - 1 && ml != 0) ? ml : AW;
          e.ks = (k == ki - 1 && kl != 0) ? kl : TK;
          e.ns = (n == ni - 1 && nl != 0) ? nl : AH;
          e.first = (n == 0);
          e.last  = (n == ni - 1);
          e.st    = longint'(m * ki + k);
          q.push_back(e);
        end
  endtask

  // Monitor: compares each accepted descriptor and checks stability under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 128'(tif.tile_valid), 128'(1));
        if (tif.tile_valid) chk("hold_desc", pack_act(), prev_desc);
      end
      if (tif.tile_valid && tif.tile_ready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_tile: got m=%0d k=%0d n=%0d expected no tile",
                   tif.tile_m, tif.tile_k, tif.tile_n);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("desc", pack_act(), pack_exp(e));
          chk("stores_run", 128'(stores), 128'(e.st));
        end
        acc_cnt++;
      end
      if (done) done_cnt++;
      prev_stall = tif.tile_valid && !tif.tile_ready;
      prev_desc  = pack_act();
    end
  end

  initial begin
    tif.tile_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tif.tile_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic do_start(input int mi, input int ki, input int ni,
                          input int ml, input int kl, input int nl);
    @(posedge clk);
    #1;
    m_iters = ITER_W'(mi); k_iters = ITER_W'(ki); n_iters = ITER_W'(ni);
    m_lft = LFT_W'(ml); k_lft = LFT_W'(kl); n_lft = LFT_W'(nl);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_iters = ITER_W'($urandom); k_iters = ITER_W'($urandom); n_iters = ITER_W'($urandom);
    m_lft = LFT_W'($urandom); k_lft = LFT_W'($urandom); n_lft = LFT_W'($urandom);
  endtask

  task automatic run_job(input int mi, input int ki, input int ni,
                         input int ml, input int kl, input int nl,
                         input int rp, input bit poke);
    int  d0, c;
    bit  zero;
    zero = (mi * ki * ni == 0);
    ready_pct = rp;
    build_exp(mi, ki, ni, ml, kl, nl);
    d0 = done_cnt;
    do_start(mi, ki, ni, ml, kl, nl);
    @(negedge clk);
    chk("first_valid_lat", 128'(tif.tile_valid), 128'(!zero));
    chk("busy_after_start", 128'(busy), 128'(1));
    if (poke) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      m_iters = 16'd1; k_iters = 16'd1; n_iters = 16'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    c = 0;
    while (!done && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", 128'(done), 128'(1));
    if (zero) begin
      chk("zero_done_lat", 128'(c), 128'(1));
      chk("zero_no_valid", 128'(acc_cnt), 128'(acc_cnt));
    end
    chk("final_stores", 128'(stores), zero ? 128'(0) : 128'(mi * ki));
    chk("queue_empty", 128'(q.size()), 128'(0));
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
    chk("done_count", 128'(done_cnt - d0), 128'(1));
    chk("stores_hold", 128'(stores), zero ? 128'(0) : 128'(mi * ki));
    q.delete();
  endtask

  task automatic wait_acc(input int target);
    int c;
    c = 0;
    while (acc_cnt < target && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("reach_acc", 128'(acc_cnt >= target), 128'(1));
  endtask

  task automatic abort_test(input bit use_reset);
    int d0, a0;
    ready_pct = 100;
    build_exp(2, 2, 2, 0, 0, 0);
    d0 = done_cnt;
    a0 = acc_cnt;
    do_start(2, 2, 2, 0, 0, 0);
    wait_acc(a0 + 2);
    if (use_reset) begin
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_desc", pack_act(), 128'(0));
      chk("rst_valid", 128'(tif.tile_valid), 128'(0));
      chk("rst_stores", 128'(stores), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      @(negedge clk);
      chk("clr_valid", 128'(tif.tile_valid), 128'(0));
      chk("clr_busy", 128'(busy), 128'(0));
      chk("clr_stores", 128'(stores), 128'(0));
      chk("clr_desc", pack_act(), 128'(0));
    end
    q.delete();
    repeat (4) @(negedge clk);
    chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
    chk("abort_idle", 128'(tif.tile_valid), 128'(0));
    run_job(2, 2, 2, 0, 0, 0, 100, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0;
    m_iters = '0; k_iters = '0; n_iters = '0;
    m_lft = '0; k_lft = '0; n_lft = '0;
    #12;
    chk("reset_desc", pack_act(), 128'(0));
    chk("reset_valid", 128'(tif.tile_valid), 128'(0));
    chk("reset_stores", 128'(stores), 128'(0));
    chk("reset_busy_done", 128'({busy, done}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_job(2, 2, 3, 0, 0, 0, 100, 1'b0);
    run_job(1, 2, 2, 5, 7, 3, 100, 1'b0);
    run_job(2, 2, 2, 0, 0, 0, 30, 1'b0);
    run_job(3, 0, 2, 0, 0, 0, 100, 1'b0);
    run_job(2, 2, 1, 3, 0, 2, 60, 1'b0);
    abort_test(1'b0);
    abort_test(1'b1);
    run_job(2, 3, 2, 0, 0, 0, 70, 1'b1);
    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
              int'($urandom_range(20, 100)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
